adder_comparison: RTL and testbench
===================================

ADDER_COMPARISON -- requirements
Module: adder_comparison

Interface
REQ-001 Parameters: none; all widths are fixed as listed below.
REQ-002 clk  input  1  single clock; all registers update on its rising edge.
REQ-003 n_rst  input  1  reset, synchronous and active-high: when 1 at a rising clk edge, all registers clear.
REQ-004 a  input  256  a[127:0] is combinational-adder operand A; a[255:128] is pipelined-adder operand A.
REQ-005 b  input  256  b[127:0] is combinational-adder operand B; b[255:128] is pipelined-adder operand B.
REQ-006 s  output  258  s[128:0] is the combinational sum; s[257:129] is the pipelined sum.

Function
REQ-007 s[128:0] SHALL equal the zero-extended unsigned sum a[127:0] + b[127:0]; bit 128 is the carry-out.
REQ-008 The combinational sum SHALL contain no registers and SHALL ignore clk and n_rst.
REQ-009 s[257:129] SHALL equal the zero-extended unsigned sum a[255:128] + b[255:128], with bit 257 as the carry-out.
REQ-010 Pipeline depth: three register ranks; operands present at rising edge N SHALL appear on s[257:129] immediately after rising edge N+2.
REQ-011 s[257:129] SHALL be driven directly from the third register rank, with no logic between the registers and the port.
REQ-012 Throughput: one new operand pair is accepted every cycle; back-to-back inputs SHALL produce back-to-back results in order.
REQ-013 There is no handshake; operands are sampled unconditionally every edge.
REQ-014 Stage 1 SHALL add bits [42:0] with carry-in 0 and register the 43-bit partial sum, its carry, and operand bits [127:43].
REQ-015 Stage 2 SHALL add bits [85:43] plus the stage-1 carry and register the partial sum and carry; it SHALL forward the lower sum bits and operand bits [127:86].
REQ-016 Stage 3 SHALL add bits [127:86] plus the stage-2 carry and register the full 129-bit result, including the final carry-out.
REQ-017 Each stage's combinational path SHALL be at most about one third of the 128-bit combinational adder's path.
REQ-018 Arithmetic is unsigned modulo 2^129 and cannot overflow; the all-ones case yields {all-ones, 0}.
REQ-019 Undefined or X inputs do not need defined outputs, but reset SHALL still clear every register.

Reset
REQ-020 While n_rst=1 at a rising edge, all pipeline registers SHALL clear to 0, so s[257:129]=0 after that edge.
REQ-021 Reset mid-stream SHALL discard all in-flight results; no pre-reset result may appear after reset deasserts.
REQ-022 After n_rst deasserts, the first valid result SHALL appear 2 edges after the first sampling edge, and the pipe SHALL output 0 until then.
REQ-023 Reset SHALL NOT affect s[128:0].

Verification
REQ-024 Reset with all inputs 0 -> s[128:0]=0 and s[257:129]=0.
REQ-025 Comb 2+5 and pipe 3+6 -> comb reads 7 after settling; pipe reads 9 after the third rising edge following the input change.
REQ-026 Comb and pipe both all-ones + all-ones -> each reads 129'h1_FFFF..._FFFE (MSB carry 1, bit 0 cleared).
REQ-027 Stream pipe pairs (2,5), (8,12), (45,59), (13,0), one per cycle -> outputs 7, 20, 104, 13 on consecutive cycles, first one 2 edges after (2,5) is sampled; comb with the same sequence tracks each sum within one settle time.
REQ-028 Carry across stage boundaries: pipe operands 2^43-1 + 1 and 2^86-1 + 1 -> 2^43 and 2^86 respectively.
REQ-029 Reset asserted one cycle after streaming starts -> pipe output 0 for the reset cycle and after, with no stale sums emerging.

Source files
------------

// File: rtl/adder_comparison.sv
// adder_comparison
//
// Two 128-bit unsigned adders side by side for timing comparison:
//   - a purely combinational adder on the low operand halves
//   - a three-stage pipelined adder on the high operand halves, split into
//     43/43/42-bit slices with the carry registered between stages
//
// Ports:
//   clk    in   1    clock, all registers update on the rising edge
//   n_rst  in   1    synchronous reset, active-high (clears pipeline only)
//   a      in   256  a[127:0] comb operand A, a[255:128] pipe operand A
//   b      in   256  b[127:0] comb operand B, b[255:128] pipe operand B
//   s      out  258  s[128:0] comb sum, s[257:129] pipe sum (3 register ranks)

module adder_comparison (
    input  logic         clk,
    input  logic         n_rst,
    input  logic [255:0] a,
    input  logic [255:0] b,
    output logic [257:0] s
);

    // ------------------------------------------------------------------
    // Combinational adder: no registers, independent of clk/n_rst
    // ------------------------------------------------------------------
    logic [128:0] comb_sum;

    always_comb begin
        comb_sum = {1'b0, a[127:0]} + {1'b0, b[127:0]};
    end

    // ------------------------------------------------------------------
    // Pipelined adder
    // ------------------------------------------------------------------
    logic [127:0] pa;
    logic [127:0] pb;

    assign pa = a[255:128];
    assign pb = b[255:128];

    // Stage 1: bits [42:0], carry-in 0; carry the untouched upper operand bits
    logic [43:0]  st1_sum;
    logic [42:0]  s1_sum_d, s1_sum_q;
    logic         s1_c_d,   s1_c_q;
    logic [84:0]  s1_a_d,   s1_a_q;
    logic [84:0]  s1_b_d,   s1_b_q;

    always_comb begin
        st1_sum  = {1'b0, pa[42:0]} + {1'b0, pb[42:0]};
        s1_sum_d = st1_sum[42:0];
        s1_c_d   = st1_sum[43];
        s1_a_d   = pa[127:43];
        s1_b_d   = pb[127:43];
    end

    // Stage 2: bits [85:43] plus stage-1 carry; forward low sum bits
    logic [43:0]  st2_sum;
    logic [85:0]  s2_sum_d, s2_sum_q;
    logic         s2_c_d,   s2_c_q;
    logic [41:0]  s2_a_d,   s2_a_q;
    logic [41:0]  s2_b_d,   s2_b_q;

    always_comb begin
        st2_sum  = {1'b0, s1_a_q[42:0]} + {1'b0, s1_b_q[42:0]} + {43'd0, s1_c_q};
        s2_sum_d = {st2_sum[42:0], s1_sum_q};
        s2_c_d   = st2_sum[43];
        s2_a_d   = s1_a_q[84:43];
        s2_b_d   = s1_b_q[84:43];
    end

    // Stage 3: bits [127:86] plus stage-2 carry; top bit is the final carry-out
    logic [42:0]  st3_sum;
    logic [128:0] s3_sum_d, s3_sum_q;

    always_comb begin
        st3_sum  = {1'b0, s2_a_q} + {1'b0, s2_b_q} + {42'd0, s2_c_q};
        s3_sum_d = {st3_sum, s2_sum_q};
    end

    always_ff @(posedge clk) begin
        if (n_rst) begin
            s1_sum_q <= '0;
            s1_c_q   <= 1'b0;
            s1_a_q   <= '0;
            s1_b_q   <= '0;
            s2_sum_q <= '0;
            s2_c_q   <= 1'b0;
            s2_a_q   <= '0;
            s2_b_q   <= '0;
            s3_sum_q <= '0;
        end else begin
            s1_sum_q <= s1_sum_d;
            s1_c_q   <= s1_c_d;
            s1_a_q   <= s1_a_d;
            s1_b_q   <= s1_b_d;
            s2_sum_q <= s2_sum_d;
            s2_c_q   <= s2_c_d;
            s2_a_q   <= s2_a_d;
            s2_b_q   <= s2_b_d;
            s3_sum_q <= s3_sum_d;
        end
    end

    // Pipe output comes straight from the third register rank
    assign s = {s3_sum_q, comb_sum};

endmodule

// File: tb/tb_adder_comparison.sv
module tb_adder_comparison;

    logic         clk;
    logic         n_rst;
    logic [255:0] a;
    logic [255:0] b;
    logic [257:0] s;

    adder_comparison dut (
        .clk   (clk),
        .n_rst (n_rst),
        .a     (a),
        .b     (b),
        .s     (s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard entry: {expected pipe sum, expected comb sum}
    logic [257:0] exp_q[$];

    int total = 0;
    int bad   = 0;

    // Delay line of hand-computed pipe sums: value sampled at edge N
    // becomes visible after edge N+2; reset at an edge empties it.
    logic [128:0] m1, m2, m3;
    logic         cur_rst;
    logic [128:0] cur_pe;

    localparam logic [127:0] ONES    = {128{1'b1}};
    localparam logic [128:0] ONES_SUM = 129'h1_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE;
    localparam logic [127:0] M43     = 128'h7FF_FFFF_FFFF;
    localparam logic [128:0] P43     = 129'h800_0000_0000;
    localparam logic [127:0] M86     = 128'h3F_FFFF_FFFF_FFFF_FFFF_FFFF;
    localparam logic [128:0] P86     = 129'h40_0000_0000_0000_0000_0000;

    task automatic drive_cycle(input logic r,
                               input logic [127:0] ca, input logic [127:0] cb,
                               input logic [128:0] ce,
                               input logic [127:0] pa, input logic [127:0] pb,
                               input logic [128:0] pe);
        @(posedge clk);
        if (cur_rst) begin
            m1 = '0; m2 = '0; m3 = '0;
        end else begin
            m3 = m2; m2 = m1; m1 = cur_pe;
        end
        #1;
        n_rst   = r;
        a       = {pa, ca};
        b       = {pb, cb};
        cur_rst = r;
        cur_pe  = pe;
        exp_q.push_back({m3, ce});
    endtask

    // Monitor: checks every cycle once expectations exist
    initial begin
        logic [257:0] e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if (s[128:0] !== e[128:0]) begin
                    bad++;
                    $display("FAIL comb t=%0t got=%h want=%h", $time, s[128:0], e[128:0]);
                end
                total++;
                if (s[257:129] !== e[257:129]) begin
                    bad++;
                    $display("FAIL pipe t=%0t got=%h want=%h", $time, s[257:129], e[257:129]);
                end
            end
        end
    end

    // Watchdog
    initial begin
        #100000;
        $display("FAIL timeout t=%0t got=running want=finished", $time);
        $fatal(1, "timeout");
    end

    initial begin
        n_rst   = 1'b1;
        a       = '0;
        b       = '0;
        cur_rst = 1'b1;
        cur_pe  = '0;
        m1 = '0; m2 = '0; m3 = '0;

        // Reset with all-zero inputs
        drive_cycle(1'b1, 128'd0, 128'd0, 129'd0, 128'd0, 128'd0, 129'd0);
        drive_cycle(1'b1, 128'd0, 128'd0, 129'd0, 128'd0, 128'd0, 129'd0);

        // Comb 2+5, pipe 3+6, held long enough to emerge
        repeat (4) drive_cycle(1'b0, 128'd2, 128'd5, 129'd7, 128'd3, 128'd6, 129'd9);

        // All-ones on both adders
        repeat (4) drive_cycle(1'b0, ONES, ONES, ONES_SUM, ONES, ONES, ONES_SUM);

        // Back-to-back stream
        drive_cycle(1'b0, 128'd2,  128'd5,  129'd7,   128'd2,  128'd5,  129'd7);
        drive_cycle(1'b0, 128'd8,  128'd12, 129'd20,  128'd8,  128'd12, 129'd20);
        drive_cycle(1'b0, 128'd45, 128'd59, 129'd104, 128'd45, 128'd59, 129'd104);
        drive_cycle(1'b0, 128'd13, 128'd0,  129'd13,  128'd13, 128'd0,  129'd13);

        // Carries across stage boundaries
        drive_cycle(1'b0, M43, 128'd1, P43, M43, 128'd1, P43);
        drive_cycle(1'b0, M86, 128'd1, P86, M86, 128'd1, P86);
        drive_cycle(1'b0, M86, 128'd1, P86, M43, 128'd1, P43);
        repeat (3) drive_cycle(1'b0, 128'd0, 128'd0, 129'd0, 128'd0, 128'd0, 129'd0);

        // Reset one cycle into a stream: in-flight sums must vanish
        drive_cycle(1'b0, 128'd2,  128'd5,  129'd7,   128'd2,  128'd5,  129'd7);
        drive_cycle(1'b1, 128'd8,  128'd12, 129'd20,  128'd8,  128'd12, 129'd20);
        drive_cycle(1'b0, 128'd45, 128'd59, 129'd104, 128'd45, 128'd59, 129'd104);
        drive_cycle(1'b0, 128'd13, 128'd0,  129'd13,  128'd13, 128'd0,  129'd13);
        repeat (4) drive_cycle(1'b0, 128'd0, 128'd0, 129'd0, 128'd0, 128'd0, 129'd0);

        repeat (2) @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d want=0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
